// File: rtl/flow_meter_pkg.sv
// Shared state encoding and default timing constants for the flow pulse meter.
package flow_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRIME   = 2'd1,
      ST_FLOWING = 2'd2,
      ST_DRY     = 2'd3
   } state_e;

   localparam int DEF_WINDOW_CYC  = 1_000_000;
   localparam int DEF_TIMEOUT_CYC = 3_000_000;
   localparam int DEF_FILT_CYC    = 4;

endpackage

// File: rtl/flow_pulse_meter_pulse_sync_edge.sv
// Synchroniser and rising-edge detector for the raw flow sensor pulse train.
// With FLOW_FILTER_EN defined, a FILT_CYC-sample stability filter sits between synchroniser and edge register.
module pulse_sync_edge
   import flow_meter_pkg::*;
#(
   parameter int FILT_CYC = DEF_FILT_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic d_async,
   output logic edge_pulse
);

   logic meta_q;
   logic sync_q;
   logic level;
   logic levelPrev_q;
   logic edge_q;

   if (FILT_CYC < 1) begin : gBadFilt
      $error("pulse_sync_edge: FILT_CYC must be at least 1");
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_async;
         sync_q <= meta_q;
      end
   end

`ifdef FLOW_FILTER_EN
   localparam int CW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
   localparam logic [CW-1:0] RUN_LAST = CW'(FILT_CYC - 1);

   logic          filt_q, filt_d;
   logic [CW-1:0] run_q, run_d;

   // Count consecutive samples that disagree with the filtered level; flip once the run is long enough.
   always_comb begin
      filt_d = filt_q;
      run_d  = '0;
      if (sync_q != filt_q) begin
         if (run_q == RUN_LAST) begin
            filt_d = sync_q;
         end else begin
            run_d = run_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q <= 1'b0;
         run_q  <= '0;
      end else begin
         filt_q <= filt_d;
         run_q  <= run_d;
      end
   end

   assign level = filt_q;
`else
   assign level = sync_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         levelPrev_q <= 1'b0;
         edge_q      <= 1'b0;
      end else begin
         levelPrev_q <= level;
         edge_q      <= level & ~levelPrev_q;
      end
   end

   assign edge_pulse = edge_q;

endmodule

// File: rtl/flow_pulse_meter.sv
// Flow pulse meter: volume accumulator, windowed flow rate and pump dry-run supervision FSM.
// Define FLOW_FILTER_EN to insert the glitch filter on the sensor path.
module flow_pulse_meter
   import flow_meter_pkg::*;
#(
   parameter int WINDOW_CYC  = DEF_WINDOW_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int VOL_W       = 24,
   parameter int RATE_W      = 16,
   parameter int FILT_CYC    = DEF_FILT_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pump_on,
   input  logic              sensor_in,
   input  logic              clr_vol,
   output logic [VOL_W-1:0]  pulse_cnt,
   output logic [RATE_W-1:0] rate,
   output logic              rate_valid,
   output logic              flow_ok,
   output logic              dry_alarm,
   output logic [1:0]        state
);

   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam int WW = $clog2(WINDOW_CYC);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW_CYC - 1);

   logic              edge_pulse;
   state_e            state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [VOL_W-1:0]  volCnt_q, volCnt_d;
   logic [WW-1:0]     winCnt_q, winCnt_d;
   logic [RATE_W-1:0] winEdges_q, winEdges_d, winEdgesInc;
   logic [RATE_W-1:0] rate_q, rate_d;
   logic              rateValid_q, rateValid_d;

   pulse_sync_edge #(
      .FILT_CYC(FILT_CYC)
   ) uSyncEdge (
      .clk       (clk),
      .rst       (rst),
      .d_async   (sensor_in),
      .edge_pulse(edge_pulse)
   );

   // Timer runs only in PRIME/FLOWING and restarts on every edge; dropping the pump command always wins.
   always_comb begin
      state_d = state_q;
      timer_d = '0;
      if (!pump_on) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_PRIME;
            ST_PRIME, ST_FLOWING: begin
               if (edge_pulse) begin
                  state_d = ST_FLOWING;
               end else if (timer_q == TIMER_LAST) begin
                  state_d = ST_DRY;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            ST_DRY:  state_d = ST_DRY;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      volCnt_d = volCnt_q;
      if (clr_vol) begin
         volCnt_d = '0;
      end else if (edge_pulse && (state_q == ST_PRIME || state_q == ST_FLOWING) && !(&volCnt_q)) begin
         volCnt_d = volCnt_q + 1'b1;
      end
   end

   // The window's closing cycle reports its own edge too, so the rate is taken from the incremented count.
   always_comb begin
      winEdgesInc = winEdges_q;
      if (edge_pulse && !(&winEdges_q)) begin
         winEdgesInc = winEdges_q + 1'b1;
      end
      winCnt_d    = winCnt_q + 1'b1;
      winEdges_d  = winEdgesInc;
      rate_d      = rate_q;
      rateValid_d = 1'b0;
      if (winCnt_q == WIN_LAST) begin
         winCnt_d    = '0;
         winEdges_d  = '0;
         rate_d      = winEdgesInc;
         rateValid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         volCnt_q    <= '0;
         winCnt_q    <= '0;
         winEdges_q  <= '0;
         rate_q      <= '0;
         rateValid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         volCnt_q    <= volCnt_d;
         winCnt_q    <= winCnt_d;
         winEdges_q  <= winEdges_d;
         rate_q      <= rate_d;
         rateValid_q <= rateValid_d;
      end
   end

   assign pulse_cnt  = volCnt_q;
   assign rate       = rate_q;
   assign rate_valid = rateValid_q;
   assign flow_ok    = (state_q == ST_FLOWING);
   assign dry_alarm  = (state_q == ST_DRY);
   assign state      = state_q;

endmodule

// File: tb/tb_flow_pulse_meter.sv
// Randomised self-checking bench for flow_pulse_meter against a queue-based model of edge arrival times.
// Build with or without FLOW_FILTER_EN; expectations follow the macro.
module tb_flow_pulse_meter;
   import flow_meter_pkg::*;

   localparam int WINDOW_CYC  = 1000;
   localparam int TIMEOUT_CYC = 500;
   localparam int VOL_W       = 4;
   localparam int RATE_W      = 8;
   localparam int FILT_CYC    = 4;
   localparam int VOL_MAX     = 15;
   localparam int RATE_MAX    = 255;
`ifdef FLOW_FILTER_EN
   localparam int LAT  = 4 + FILT_CYC;
   localparam int MINW = FILT_CYC;
`else
   localparam int LAT  = 4;
   localparam int MINW = 1;
`endif

   logic              clk = 1'b0;
   logic              rst, pump_on, sensor_in, clr_vol;
   logic [VOL_W-1:0]  pulse_cnt;
   logic [RATE_W-1:0] rate;
   logic              rate_valid, flow_ok, dry_alarm;
   logic [1:0]        state;

   int                nChecks = 0;
   int                nFails  = 0;
   int                cyc     = 0;
   int                relCyc  = 0;
   int                edgeQ[$];
   int                rvCyc[$];
   logic [RATE_W-1:0] rvRate[$];

   flow_pulse_meter #(
      .WINDOW_CYC (WINDOW_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .VOL_W      (VOL_W),
      .RATE_W     (RATE_W),
      .FILT_CYC   (FILT_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pump_on   (pump_on),
      .sensor_in (sensor_in),
      .clr_vol   (clr_vol),
      .pulse_cnt (pulse_cnt),
      .rate      (rate),
      .rate_valid(rate_valid),
      .flow_ok   (flow_ok),
      .dry_alarm (dry_alarm),
      .state     (state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rate_valid === 1'b1) begin
         rvCyc.push_back(cyc);
         rvRate.push_back(rate);
      end
   end

   // Edges are consumed by the counters LAT posedges after the sensor rise is driven.
   function automatic int edgesIn(input int lo, input int hi);
      int n = 0;
      foreach (edgeQ[i]) if (edgeQ[i] > lo && edgeQ[i] <= hi) n++;
      return n;
   endfunction

   function automatic int windowRate(input int i);
      int n = edgesIn(relCyc + WINDOW_CYC * i, relCyc + WINDOW_CYC * (i + 1));
      return (n > RATE_MAX) ? RATE_MAX : n;
   endfunction

   function automatic int satVol(input int n);
      return (n > VOL_MAX) ? VOL_MAX : n;
   endfunction

   task automatic step(input logic s);
      sensor_in = s;
      @(negedge clk);
   endtask

   task automatic pulse(input int width, input int gap);
      if (width >= MINW) edgeQ.push_back(cyc + LAT);
      repeat (width) step(1'b1);
      repeat (gap) step(1'b0);
   endtask

   task automatic doReset();
      rst = 1'b1; pump_on = 1'b0; sensor_in = 1'b0; clr_vol = 1'b0;
      repeat (3) @(negedge clk);
      edgeQ.delete(); rvCyc.delete(); rvRate.delete();
      rst = 1'b0;
      relCyc = cyc;
   endtask

   task automatic test_reset();
      rst = 1'b1; pump_on = 1'b1; sensor_in = 1'b0; clr_vol = 1'b0;
      repeat (2) @(negedge clk);
      nChecks++; if (pulse_cnt !== '0) begin nFails++; $display("[TB] FAIL reset_pulse_cnt: got %0d want 0", pulse_cnt); end
      nChecks++; if (rate !== '0) begin nFails++; $display("[TB] FAIL reset_rate: got %0d want 0", rate); end
      nChecks++; if (rate_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rate_valid: got %b want 0", rate_valid); end
      nChecks++; if (flow_ok !== 1'b0) begin nFails++; $display("[TB] FAIL reset_flow_ok: got %b want 0", flow_ok); end
      nChecks++; if (dry_alarm !== 1'b0) begin nFails++; $display("[TB] FAIL reset_dry_alarm: got %b want 0", dry_alarm); end
      nChecks++; if (state !== ST_IDLE) begin nFails++; $display("[TB] FAIL reset_state: got %0d want %0d", state, ST_IDLE); end
      doReset();
      repeat (5) step(1'b0);
      nChecks++; if (state !== ST_IDLE) begin nFails++; $display("[TB] FAIL idle_no_pump: state %0d want %0d", state, ST_IDLE); end
   endtask

   task automatic test_flow_rate(input int period);
      int nWin;
      doReset();
      pump_on = 1'b1;
      repeat ($urandom_range(0, period - 1)) step(1'b0);
      while (cyc - relCyc < 3000) pulse(period / 2, period - period / 2);
      repeat (LAT + 2) step(1'b0);
      #1;
      nChecks++; if (state !== ST_FLOWING) begin nFails++; $display("[TB] FAIL flow_state(P=%0d): got %0d want %0d", period, state, ST_FLOWING); end
      nChecks++; if (flow_ok !== 1'b1) begin nFails++; $display("[TB] FAIL flow_ok(P=%0d): got %b want 1", period, flow_ok); end
      nChecks++; if (pulse_cnt !== VOL_W'(satVol(edgesIn(0, cyc)))) begin nFails++; $display("[TB] FAIL flow_vol(P=%0d): got %0d want %0d", period, pulse_cnt, satVol(edgesIn(0, cyc))); end
      nWin = (cyc - relCyc) / WINDOW_CYC;
      nChecks++; if (rvCyc.size() != nWin) begin nFails++; $display("[TB] FAIL flow_nwin(P=%0d): got %0d want %0d", period, rvCyc.size(), nWin); end
      for (int i = 0; i < rvCyc.size() && i < nWin; i++) begin
         nChecks++; if (rvCyc[i] != relCyc + WINDOW_CYC * (i + 1)) begin nFails++; $display("[TB] FAIL flow_rv_time[%0d]: got %0d want %0d", i, rvCyc[i] - relCyc, WINDOW_CYC * (i + 1)); end
         nChecks++; if (rvRate[i] !== RATE_W'(windowRate(i))) begin nFails++; $display("[TB] FAIL flow_rate[%0d](P=%0d): got %0d want %0d", i, period, rvRate[i], windowRate(i)); end
      end
   endtask

   task automatic test_dry_prime();
      int start, seen;
      doReset();
      repeat ($urandom_range(1, 20)) step(1'b0);
      pump_on = 1'b1;
      start = cyc;
      step(1'b0);
      nChecks++; if (state !== ST_PRIME) begin nFails++; $display("[TB] FAIL prime_state: got %0d want %0d", state, ST_PRIME); end
      seen = -1;
      for (int i = 0; i < 2 * TIMEOUT_CYC && seen < 0; i++) begin
         step(1'b0);
         if (dry_alarm === 1'b1) seen = cyc;
      end
      nChecks++; if (seen != start + 1 + TIMEOUT_CYC) begin nFails++; $display("[TB] FAIL prime_dry_time: got %0d want %0d cycles after PRIME", seen - start - 1, TIMEOUT_CYC); end
      nChecks++; if (state !== ST_DRY) begin nFails++; $display("[TB] FAIL prime_dry_state: got %0d want %0d", state, ST_DRY); end
      pump_on = 1'b0;
      step(1'b0);
      nChecks++; if (state !== ST_IDLE) begin nFails++; $display("[TB] FAIL dry_exit_state: got %0d want %0d", state, ST_IDLE); end
      nChecks++; if (dry_alarm !== 1'b0) begin nFails++; $display("[TB] FAIL dry_exit_alarm: got %b want 0", dry_alarm); end
   endtask

   task automatic test_flow_timeout();
      int n, last, seen, volBefore;
      doReset();
      pump_on = 1'b1;
      n = $urandom_range(3, 8);
      repeat (n) pulse($urandom_range(10, 30), $urandom_range(10, 30));
      last = edgeQ[edgeQ.size() - 1];
      seen = -1;
      for (int i = 0; i < 2 * TIMEOUT_CYC && seen < 0; i++) begin
         step(1'b0);
         if (dry_alarm === 1'b1) seen = cyc;
      end
      nChecks++; if (seen != last + TIMEOUT_CYC) begin nFails++; $display("[TB] FAIL flowing_dry_time: got %0d want %0d cycles after last edge", seen - last, TIMEOUT_CYC); end
      volBefore = satVol(n);
      repeat (3) pulse($urandom_range(MINW, 12), $urandom_range(6, 12));
      repeat (LAT + 2) step(1'b0);
      nChecks++; if (pulse_cnt !== VOL_W'(volBefore)) begin nFails++; $display("[TB] FAIL dry_ignores_edges: got %0d want %0d", pulse_cnt, volBefore); end
      nChecks++; if (state !== ST_DRY) begin nFails++; $display("[TB] FAIL dry_latched: got %0d want %0d", state, ST_DRY); end
      pump_on = 1'b0;
      step(1'b0);
      nChecks++; if (state !== ST_IDLE) begin nFails++; $display("[TB] FAIL timeout_exit_state: got %0d want %0d", state, ST_IDLE); end
   endtask

   task automatic test_vol_sat_clear();
      int x;
      doReset();
      pump_on = 1'b1;
      repeat (20) pulse($urandom_range(MINW, 10), $urandom_range(5, 10));
      repeat (LAT + 2) step(1'b0);
      nChecks++; if (pulse_cnt !== VOL_W'(satVol(edgesIn(0, cyc)))) begin nFails++; $display("[TB] FAIL vol_saturate: got %0d want %0d", pulse_cnt, satVol(edgesIn(0, cyc))); end
      x = cyc + LAT;
      edgeQ.push_back(x);
      sensor_in = 1'b1;
      while (cyc < x - 1) step(1'b1);
      clr_vol = 1'b1;
      step(1'b1);
      clr_vol = 1'b0;
      #1;
      nChecks++; if (pulse_cnt !== VOL_W'(satVol(edgesIn(x, cyc)))) begin nFails++; $display("[TB] FAIL clr_with_edge: got %0d want %0d", pulse_cnt, satVol(edgesIn(x, cyc))); end
      repeat (10) step(1'b0);
      pulse($urandom_range(MINW, 10), 6);
      repeat (LAT + 2) step(1'b0);
      nChecks++; if (pulse_cnt !== VOL_W'(satVol(edgesIn(x, cyc)))) begin nFails++; $display("[TB] FAIL count_after_clr: got %0d want %0d", pulse_cnt, satVol(edgesIn(x, cyc))); end
   endtask

   task automatic test_reset_mid();
      doReset();
      pump_on = 1'b1;
      repeat (7) pulse($urandom_range(10, 20), $urandom_range(10, 20));
      repeat (LAT + 2 + $urandom_range(0, 100)) step(1'b0);
      nChecks++; if (pulse_cnt !== VOL_W'(7)) begin nFails++; $display("[TB] FAIL mid_pre_vol: got %0d want 7", pulse_cnt); end
      nChecks++; if (state !== ST_FLOWING) begin nFails++; $display("[TB] FAIL mid_pre_state: got %0d want %0d", state, ST_FLOWING); end
      rst = 1'b1;
      #1;
      nChecks++; if (pulse_cnt !== '0) begin nFails++; $display("[TB] FAIL mid_rst_vol: got %0d want 0", pulse_cnt); end
      nChecks++; if (state !== ST_IDLE || flow_ok !== 1'b0 || dry_alarm !== 1'b0) begin nFails++; $display("[TB] FAIL mid_rst_fsm: state %0d flow_ok %b dry %b want 0 0 0", state, flow_ok, dry_alarm); end
      nChecks++; if (rate !== '0 || rate_valid !== 1'b0) begin nFails++; $display("[TB] FAIL mid_rst_rate: rate %0d valid %b want 0 0", rate, rate_valid); end
      pump_on = 1'b0;
      repeat (2) @(negedge clk);
      edgeQ.delete(); rvCyc.delete(); rvRate.delete();
      rst = 1'b0;
      relCyc = cyc;
      repeat (WINDOW_CYC + 50) step(1'b0);
      #1;
      nChecks++;
      if (rvCyc.size() < 1) begin
         nFails++; $display("[TB] FAIL mid_first_rv: no rate_valid within %0d cycles", WINDOW_CYC + 50);
      end else if (rvCyc[0] != relCyc + WINDOW_CYC || rvRate[0] !== '0) begin
         nFails++; $display("[TB] FAIL mid_first_rv: at %0d rate %0d want at %0d rate 0", rvCyc[0] - relCyc, rvRate[0], WINDOW_CYC);
      end
   endtask

   task automatic test_rate_windows(input int width, input int gap, input bit aligned);
      int nWin;
      doReset();
      repeat ($urandom_range(2, 6)) pulse($urandom_range(MINW, 10), $urandom_range(5, 10));
      if (aligned) begin
         while (cyc < relCyc + WINDOW_CYC - LAT) step(1'b0);
         pulse(MINW, 6);
      end
      while (cyc - relCyc < 2 * WINDOW_CYC + 5) pulse(width, gap);
      repeat (LAT + 2) step(1'b0);
      #1;
      nChecks++; if (state !== ST_IDLE || pulse_cnt !== '0) begin nFails++; $display("[TB] FAIL idle_ignores_vol: state %0d vol %0d want 0 0", state, pulse_cnt); end
      nWin = (cyc - relCyc) / WINDOW_CYC;
      nChecks++; if (rvCyc.size() != nWin) begin nFails++; $display("[TB] FAIL rate_nwin: got %0d want %0d", rvCyc.size(), nWin); end
      for (int i = 0; i < rvCyc.size() && i < nWin; i++) begin
         nChecks++; if (rvRate[i] !== RATE_W'(windowRate(i))) begin nFails++; $display("[TB] FAIL rate_window[%0d]: got %0d want %0d", i, rvRate[i], windowRate(i)); end
      end
   endtask

   task automatic test_glitch();
      doReset();
      pump_on = 1'b1;
      repeat (10) pulse(2, 10);
      repeat (LAT + 2) step(1'b0);
      nChecks++; if (pulse_cnt !== VOL_W'(satVol(edgesIn(0, cyc)))) begin nFails++; $display("[TB] FAIL short_pulses: got %0d want %0d", pulse_cnt, satVol(edgesIn(0, cyc))); end
      nChecks++; if (state !== ((edgesIn(0, cyc) > 0) ? ST_FLOWING : ST_PRIME)) begin nFails++; $display("[TB] FAIL short_pulse_state: got %0d", state); end
      repeat (4) pulse(10, 10);
      repeat (LAT + 2) step(1'b0);
      nChecks++; if (pulse_cnt !== VOL_W'(satVol(edgesIn(0, cyc)))) begin nFails++; $display("[TB] FAIL wide_pulses: got %0d want %0d", pulse_cnt, satVol(edgesIn(0, cyc))); end
   endtask

   initial begin
      test_reset();
      test_flow_rate(100);
      test_flow_rate($urandom_range(20, 300));
      test_dry_prime();
      test_flow_timeout();
      test_vol_sat_clear();
      test_reset_mid();
      test_rate_windows(MINW, (MINW > 2) ? MINW : 2, 1'b0);
      test_rate_windows($urandom_range(MINW, 8), $urandom_range(5, 40), 1'b1);
      test_glitch();
      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

   initial begin
      #2_000_000;
      nFails++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule
